// File: rtl/neuron_stream_feeder.sv
// neuron_stream_feeder: packs four serial activations into X1..X4, holds them COMP_LAT cycles, then presents the captured Y on a valid/ready stream
// Ports: clk/rst_n (async active-low reset); in_data/in_valid/in_ready/in_last input stream;
// x1..x4 packed vector to the external neuron (x1 = first sample); y_in neuron result;
// out_data/out_valid/out_ready result stream; busy high unless idle in FILL with no partial vector.
// Optional LAST_CHECK_EN macro adds err_last (sticky in_last framing error) and err_clr (sync clear).
module neuron_stream_feeder #(
  parameter int DATA_W   = 8,
  parameter int COMP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef LAST_CHECK_EN
  ,
  output logic              err_last,
  input  logic              err_clr
`endif
);
  typedef enum logic [1:0] {FILL, HOLD, OUT} state_t;
  localparam logic [3:0] LAT = 4'(COMP_LAT);
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        wait_q, wait_d;
  logic [DATA_W-1:0] x_q [4];
  logic [DATA_W-1:0] x_d [4];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;
  assign in_ready  = state_q == FILL;
  assign accept    = in_valid && in_ready;
  assign busy      = !(state_q == FILL && cnt_q == 2'd0);
  assign x1        = x_q[0];
  assign x2        = x_q[1];
  assign x3        = x_q[2];
  assign x4        = x_q[3];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef LAST_CHECK_EN
  logic err_q, err_d;
  assign err_last = err_q;
  // a set in the same cycle as a clear wins
  assign err_d = (accept && (in_last != (cnt_q == 2'd3))) ? 1'b1 : err_clr ? 1'b0 : err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      FILL: if (accept) begin
        x_d[cnt_q] = in_data;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = HOLD;
          wait_d  = LAT;
        end
`ifdef LAST_CHECK_EN
        // early in_last drops the partial vector and restarts packing at x1
        if (in_last && cnt_q != 2'd3) cnt_d = 2'd0;
`endif
      end
      HOLD: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          out_data_d  = y_in;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      wait_q      <= '0;
      x_q         <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef LAST_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      x_q         <= x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef LAST_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end
endmodule
